// File: rtl/rom_fetch_arbiter.sv
// ROM port arbiter: shares one read-only ROM port between instruction fetch
// (IF) and data-side constant loads (MEM). One access is outstanding at a time.
// The ROM latency is absorbed here, and each requester gets a stall signal.
module rom_fetch_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned ROM_LATENCY   = 1,
  parameter int unsigned MEM_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rvalid,
  output logic              mem_stall,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata
);

  localparam int unsigned CNT_W = $clog2(ROM_LATENCY + 1);
  localparam int unsigned STK_W = $clog2(MEM_BURST_MAX + 1);
  // The counter is cleared on the issue edge, so delivery falls on count L-1.
  // With ROM_LATENCY=1 this is the cycle right after the issue edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ROM_LATENCY - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MEM_BURST_MAX);

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic {OWN_IF, OWN_MEM} owner_t;

  state_t           state;
  owner_t           owner;
  logic [CNT_W-1:0] cnt;
  logic [STK_W-1:0] streak;
  logic             dropped;

  logic deliver, grant_pt, if_elig, grant_if, grant_mem, grant;

  // Delivery detection and arbitration.
  // MEM wins by default. IF wins once MEM has had its burst allowance.
  always_comb begin
    deliver   = (state == BUSY) && (cnt == CNT_LAST);
    grant_pt  = (state == IDLE) || deliver;
    if_elig   = if_req && !if_flush;
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (grant_pt) begin
      if (if_elig && (streak == STK_MAX)) grant_if  = 1'b1;
      else if (mem_req)                   grant_mem = 1'b1;
      else if (if_elig)                   grant_if  = 1'b1;
    end
    grant = grant_if || grant_mem;
  end

  // Response steering and stalls.
  // A flush in the delivery cycle also discards the IF data.
  // The stall outputs are forced low while reset is asserted.
  always_comb begin
    if_rvalid  = deliver && (owner == OWN_IF) && !dropped && !if_flush;
    mem_rvalid = deliver && (owner == OWN_MEM);
    if_rdata   = if_rvalid  ? rom_rdata : '0;
    mem_rdata  = mem_rvalid ? rom_rdata : '0;
    if_stall   = rst && if_req  && !if_rvalid;
    mem_stall  = rst && mem_req && !mem_rvalid;
  end

  // Access sequencing: issue the ROM request, count latency, track ownership
  // and flush-drop, and track the MEM streak used for IF fairness.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      cnt      <= '0;
      streak   <= '0;
      dropped  <= 1'b0;
      rom_en   <= 1'b0;
      rom_addr <= '0;
    end else begin
      rom_en <= grant;
      if (grant) begin
        state    <= BUSY;
        cnt      <= '0;
        dropped  <= 1'b0;
        owner    <= grant_mem ? OWN_MEM : OWN_IF;
        rom_addr <= grant_mem ? mem_addr : if_addr;
      end else if (deliver) begin
        state   <= IDLE;
        dropped <= 1'b0;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
        if (if_flush && (owner == OWN_IF)) dropped <= 1'b1;
      end

      if (!if_req || grant_if)
        streak <= '0;
      else if (grant_mem && (streak != STK_MAX))
        streak <= streak + STK_W'(1);
    end
  end

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// Directed bench for rom_fetch_arbiter.
// Two instances are used: index 0 has ROM_LATENCY=1 and index 1 has ROM_LATENCY=3.
// The ROM model is an address-registered read, and its data is a function of
// rom_addr. Requesters present their next request in the cycle where they see rvalid.
module tb_rom_fetch_arbiter;

  localparam logic [31:0] RTAG = 32'hC0DE_0000;

  logic        clk;
  logic        rst;
  logic        if_req     [2];
  logic [31:0] if_addr    [2];
  logic        if_flush   [2];
  logic [31:0] if_rdata   [2];
  logic        if_rvalid  [2];
  logic        if_stall   [2];
  logic        mem_req    [2];
  logic [31:0] mem_addr   [2];
  logic [31:0] mem_rdata  [2];
  logic        mem_rvalid [2];
  logic        mem_stall  [2];
  logic        rom_en     [2];
  logic [31:0] rom_addr   [2];
  logic [31:0] rom_rdata  [2];

  int checks = 0;
  int errors = 0;

  rom_fetch_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_LATENCY(1), .MEM_BURST_MAX(4)) dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_flush(if_flush[0]),
    .if_rdata(if_rdata[0]), .if_rvalid(if_rvalid[0]), .if_stall(if_stall[0]),
    .mem_req(mem_req[0]), .mem_addr(mem_addr[0]),
    .mem_rdata(mem_rdata[0]), .mem_rvalid(mem_rvalid[0]), .mem_stall(mem_stall[0]),
    .rom_en(rom_en[0]), .rom_addr(rom_addr[0]), .rom_rdata(rom_rdata[0])
  );

  rom_fetch_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_LATENCY(3), .MEM_BURST_MAX(4)) dut_l3 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_flush(if_flush[1]),
    .if_rdata(if_rdata[1]), .if_rvalid(if_rvalid[1]), .if_stall(if_stall[1]),
    .mem_req(mem_req[1]), .mem_addr(mem_addr[1]),
    .mem_rdata(mem_rdata[1]), .mem_rvalid(mem_rvalid[1]), .mem_stall(mem_stall[1]),
    .rom_en(rom_en[1]), .rom_addr(rom_addr[1]), .rom_rdata(rom_rdata[1])
  );

  assign rom_rdata[0] = rom_addr[0] ^ RTAG;
  assign rom_rdata[1] = rom_addr[1] ^ RTAG;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0; if_addr[i] = '0; if_flush[i] = 1'b0;
      mem_req[i] = 1'b0; mem_addr[i] = '0;
    end
    rst = 1'b0;

    // 1: reset with an IF request already pending
    if_req[0] = 1'b1; if_addr[0] = 32'h0;
    step(); step(); step();
    chk("rst_rom_en",   32'(rom_en[0]),    32'h0);
    chk("rst_rom_addr", rom_addr[0],       32'h0);
    chk("rst_if_rvalid",32'(if_rvalid[0]), 32'h0);
    chk("rst_if_stall", 32'(if_stall[0]),  32'h0);
    rst = 1'b1;
    step();
    chk("t1_rom_en",    32'(rom_en[0]),    32'h1);
    chk("t1_rom_addr",  rom_addr[0],       32'h0);
    chk("t1_if_rvalid", 32'(if_rvalid[0]), 32'h1);
    chk("t1_if_rdata",  if_rdata[0],       32'hC0DE_0000);
    chk("t1_if_stall",  32'(if_stall[0]),  32'h0);
    if_addr[0] = 32'h4;

    // 2: IF stream, one access per cycle
    step();
    chk("t2_rom_addr4", rom_addr[0],       32'h4);
    chk("t2_rvalid4",   32'(if_rvalid[0]), 32'h1);
    chk("t2_rdata4",    if_rdata[0],       32'hC0DE_0004);
    chk("t2_stall4",    32'(if_stall[0]),  32'h0);
    if_addr[0] = 32'h8;
    step();
    chk("t2_rom_addr8", rom_addr[0],       32'h8);
    chk("t2_rvalid8",   32'(if_rvalid[0]), 32'h1);
    chk("t2_stall8",    32'(if_stall[0]),  32'h0);
    if_req[0] = 1'b0;
    step();
    chk("t2_idle_en",   32'(rom_en[0]),    32'h0);
    chk("t2_idle_rv",   32'(if_rvalid[0]), 32'h0);

    // 3: simultaneous requests, MEM first
    if_req[0] = 1'b1; if_addr[0] = 32'h10;
    mem_req[0] = 1'b1; mem_addr[0] = 32'h2000;
    #1;
    chk("t3_if_stall0",  32'(if_stall[0]),  32'h1);
    chk("t3_mem_stall0", 32'(mem_stall[0]), 32'h1);
    step();
    chk("t3_rom_addr_m", rom_addr[0],        32'h2000);
    chk("t3_mem_rvalid", 32'(mem_rvalid[0]), 32'h1);
    chk("t3_mem_rdata",  mem_rdata[0],       32'hC0DE_2000);
    chk("t3_if_rvalid0", 32'(if_rvalid[0]),  32'h0);
    chk("t3_if_rdata0",  if_rdata[0],        32'h0);
    chk("t3_if_stall1",  32'(if_stall[0]),   32'h1);
    chk("t3_mem_stall1", 32'(mem_stall[0]),  32'h0);
    mem_req[0] = 1'b0;
    step();
    chk("t3_rom_addr_i", rom_addr[0],        32'h10);
    chk("t3_if_rvalid1", 32'(if_rvalid[0]),  32'h1);
    chk("t3_if_rdata1",  if_rdata[0],        32'hC0DE_0010);
    chk("t3_mem_rvalid1",32'(mem_rvalid[0]), 32'h0);
    chk("t3_mem_rdata1", mem_rdata[0],       32'h0);
    if_req[0] = 1'b0;
    step();
    chk("t3_idle_en",    32'(rom_en[0]),     32'h0);

    // 4: MEM burst limit of 4, then IF, then MEM resumes
    if_req[0] = 1'b1; if_addr[0] = 32'h20;
    mem_req[0] = 1'b1; mem_addr[0] = 32'h3000;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t4_mem_rv%0d", k),   32'(mem_rvalid[0]), 32'h1);
      chk($sformatf("t4_mem_addr%0d", k), rom_addr[0],        32'h3000 + 32'(4 * k));
      chk($sformatf("t4_if_rv%0d", k),    32'(if_rvalid[0]),  32'h0);
      mem_addr[0] = mem_addr[0] + 32'h4;
    end
    step();
    chk("t4_if_grant_rv",  32'(if_rvalid[0]),  32'h1);
    chk("t4_if_grant_adr", rom_addr[0],        32'h20);
    chk("t4_mem_waiting",  32'(mem_rvalid[0]), 32'h0);
    chk("t4_mem_stall",    32'(mem_stall[0]),  32'h1);
    if_req[0] = 1'b0;
    step();
    chk("t4_mem_resume_rv",  32'(mem_rvalid[0]), 32'h1);
    chk("t4_mem_resume_adr", rom_addr[0],        32'h3010);
    mem_req[0] = 1'b0;
    step();
    chk("t4_idle_en", 32'(rom_en[0]), 32'h0);

    // 5: L=3, flush while IF 0x40 is in flight
    if_req[1] = 1'b1; if_addr[1] = 32'h40;
    step();
    chk("t5_issue_en",   32'(rom_en[1]),    32'h1);
    chk("t5_issue_adr",  rom_addr[1],       32'h40);
    chk("t5_issue_rv",   32'(if_rvalid[1]), 32'h0);
    chk("t5_issue_stall",32'(if_stall[1]),  32'h1);
    if_flush[1] = 1'b1; if_addr[1] = 32'h100;
    step();
    chk("t5_c2_en", 32'(rom_en[1]),    32'h0);
    chk("t5_c2_rv", 32'(if_rvalid[1]), 32'h0);
    if_flush[1] = 1'b0;
    step();
    chk("t5_drop_rv",    32'(if_rvalid[1]), 32'h0);
    chk("t5_drop_stall", 32'(if_stall[1]),  32'h1);
    step();
    chk("t5_reissue_en",  32'(rom_en[1]),    32'h1);
    chk("t5_reissue_adr", rom_addr[1],       32'h100);
    chk("t5_reissue_rv",  32'(if_rvalid[1]), 32'h0);
    step();
    chk("t5_wait_rv", 32'(if_rvalid[1]), 32'h0);
    step();
    chk("t5_new_rv",    32'(if_rvalid[1]), 32'h1);
    chk("t5_new_rdata", if_rdata[1],       32'hC0DE_0100);
    chk("t5_new_stall", 32'(if_stall[1]),  32'h0);
    if_req[1] = 1'b0;
    step();
    chk("t5_idle_en", 32'(rom_en[1]), 32'h0);

    // 6: reset asserted mid-access on L=3
    mem_req[1] = 1'b1; mem_addr[1] = 32'h4000;
    if_req[1]  = 1'b1; if_addr[1]  = 32'h200;
    step();
    chk("t6_busy_en",  32'(rom_en[1]), 32'h1);
    chk("t6_busy_adr", rom_addr[1],    32'h4000);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_en",        32'(rom_en[1]),     32'h0);
    chk("t6_rst_adr",       rom_addr[1],        32'h0);
    chk("t6_rst_mem_rv",    32'(mem_rvalid[1]), 32'h0);
    chk("t6_rst_if_stall",  32'(if_stall[1]),   32'h0);
    chk("t6_rst_mem_stall", 32'(mem_stall[1]),  32'h0);
    step();
    rst = 1'b1;
    mem_req[1] = 1'b0; if_req[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("t6_post_mem_rv%0d", k), 32'(mem_rvalid[1]), 32'h0);
      chk($sformatf("t6_post_if_rv%0d", k),  32'(if_rvalid[1]),  32'h0);
      chk($sformatf("t6_post_en%0d", k),     32'(rom_en[1]),     32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
